// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter and the keyboard receiver.
//   - ps2_tx_state_e : host-to-device transmit FSM encoding
//   - *_DEF          : default cycle counts for a 100 MHz clock
//   - odd_parity()   : PS/2 frame parity bit for a data byte
//   - CMD_* / ACK_BYTE : common keyboard command and response bytes
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_e;

    // 100 us clock inhibit and 15 ms transfer timeout at 100 MHz
    localparam int INHIBIT_CYCLES_DEF = 10000;
    localparam int TIMEOUT_CYCLES_DEF = 1500000;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] ACK_BYTE     = 8'hFA;

    // Parity bit that makes the 9-bit {parity, data} word carry an odd number of ones
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the raw PS/2 clock and data pins, plus a
// one-cycle strobe on each falling edge of the synchronized clock.
// Shared by the host transmitter and the keyboard receiver.
//   clock, reset  : system clock, synchronous active-high reset
//   ps2_clk_i     : raw ps2_clk pin level
//   ps2_data_i    : raw ps2_data pin level
//   clk_sync_o    : synchronized ps2_clk
//   data_sync_o   : synchronized ps2_data
//   clk_fall_o    : high for one cycle when synchronized ps2_clk goes 1 -> 0
module ps2_line_sync (
    input  logic clock,
    input  logic reset,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_sync_o,
    output logic data_sync_o,
    output logic clk_fall_o
);

    logic [1:0] clk_ff_q;
    logic [1:0] data_ff_q;
    logic       clk_prev_q;

    // Reset to the idle (released, pulled-up) level so leaving reset while
    // the device holds the clock low does not produce a phantom edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_ff_q   <= 2'b11;
            data_ff_q  <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_ff_q   <= {clk_ff_q[0], ps2_clk_i};
            data_ff_q  <= {data_ff_q[0], ps2_data_i};
            clk_prev_q <= clk_ff_q[1];
        end
    end

    assign clk_sync_o  = clk_ff_q[1];
    assign data_sync_o = data_ff_q[1];
    assign clk_fall_o  = clk_prev_q & ~clk_ff_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard
// over the open-drain ps2_clk/ps2_data lines, driving them only through
// active-high pull-low enables; the top level builds the tristates.
//   clock, reset   : system clock, synchronous active-high reset
//   tx_valid_i     : request to send tx_data_i
//   tx_data_i      : command byte, sampled only when accepted
//   tx_ready_o     : high only in IDLE; accept = tx_valid_i & tx_ready_o
//   tx_done_o      : one-cycle pulse, device ACKed and lines idle
//   tx_error_o     : one-cycle pulse, timeout or missing ACK
//   busy_o         : high in every state but IDLE (gates the receiver)
//   ps2_clk_i      : raw ps2_clk pin level
//   ps2_data_i     : raw ps2_data pin level
//   ps2_clk_oe_o   : 1 = pull ps2_clk low
//   ps2_data_oe_o  : 1 = pull ps2_data low
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | lines released, ready for a byte
// INHIBIT   | hold ps2_clk low for INHIBIT_CYCLES
// RTS       | one cycle with clk and data both low (start bit applied)
// SEND      | clk released; shift data, parity, stop on device falling edges
// ACK       | wait for the device's ACK clock, check data is low
// WAIT_IDLE | wait for device to release both lines
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tx_valid_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o,
    output logic       tx_done_o,
    output logic       tx_error_o,
    output logic       busy_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    // Down-counters load N-1 so that the terminal count (zero) is the Nth cycle
    localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_e    state_q, state_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [8:0]       frame_q, frame_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic clk_sync;
    logic data_sync;
    logic clk_fall;

    ps2_line_sync u_sync (
        .clock       (clock),
        .reset       (reset),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .clk_sync_o  (clk_sync),
        .data_sync_o (data_sync),
        .clk_fall_o  (clk_fall)
    );

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                data_oe_d = 1'b0;
                if (tx_valid_i) begin
                    frame_d   = {odd_parity(tx_data_i), tx_data_i};
                    inh_cnt_d = INH_LOAD;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt_q == '0) begin
                    data_oe_d = 1'b1;
                    state_d   = RTS;
                end else begin
                    inh_cnt_d = inh_cnt_q - INH_W'(1);
                end
            end
            RTS: begin
                to_cnt_d  = TO_LOAD;
                bit_cnt_d = 4'd0;
                state_d   = SEND;
            end
            SEND: begin
                // Edge k (bit_cnt_q = k-1 before it) presents frame bit k-1;
                // edge 10 releases data for the stop bit.
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        data_oe_d = 1'b0;
                        state_d   = ACK;
                    end else begin
                        data_oe_d = ~frame_q[bit_cnt_q];
                    end
                end
            end
            ACK: begin
                if (clk_fall) begin
                    if (!data_sync) begin
                        state_d = WAIT_IDLE;
                    end else begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Timeout overrides any event in the same cycle, so done and error
        // can never pulse together.
        if (state_q inside {SEND, ACK, WAIT_IDLE}) begin
            if (to_cnt_q == '0) begin
                error_d   = 1'b1;
                done_d    = 1'b0;
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end else begin
                to_cnt_d = to_cnt_q - TO_W'(1);
            end
        end

        clk_oe_d = (state_d == INHIBIT) || (state_d == RTS);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            bit_cnt_q <= 4'd0;
            frame_q   <= 9'd0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign tx_ready_o    = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign tx_done_o     = done_q;
    assign tx_error_o    = error_q;
    assign ps2_clk_oe_o  = clk_oe_q;
    assign ps2_data_oe_o = data_oe_q;

endmodule
